// File: rtl/global_defs.sv
// global_defs: shared matrix geometry and element width for the MPU
package global_defs;
    localparam int FP = 32;
    localparam int M = 3;
    localparam int N = 3;
    localparam int MBITS = $clog2(M);
    localparam int NBITS = $clog2(N);
    localparam int NUM_ELEMENTS = M * N;
    localparam int MATRIX_REGISTERS = 4;
    localparam int MATRIX_REG_SIZE = $clog2(MATRIX_REGISTERS);
    localparam logic [MBITS:0] M_MAX = M[MBITS:0];
    localparam logic [NBITS:0] N_MAX = N[NBITS:0];
endpackage

// File: rtl/mpu_pkg.sv
// mpu_pkg: MPU operation codes and load sequencer state encoding
package mpu_pkg;
    typedef enum logic [1:0] {NOP, LOAD, STORE, COMPUTE} mpu_operation_t;
    typedef enum logic {ST_IDLE, ST_LOAD} load_state_t;
endpackage

// File: rtl/mpu_load_regfile_if.sv
// mpu_load_regfile_if: memory load stream and store-unit read port bundle
interface mpu_load_regfile_if;
    import global_defs::*;
    logic                       load_en_in;
    logic [FP-1:0]              mem_load_element_in;
    logic [MBITS:0]             mem_m_load_size_in;
    logic [NBITS:0]             mem_n_load_size_in;
    logic [MATRIX_REG_SIZE-1:0] mem_load_addr_in;
    logic                       mem_load_error_out;
    logic                       mem_load_ack_out;
    logic                       reg_store_en_in;
    logic [MATRIX_REG_SIZE-1:0] reg_store_addr_in;
    logic [MBITS:0]             reg_i_store_loc_in;
    logic [NBITS:0]             reg_j_store_loc_in;
    logic [FP-1:0]              reg_store_element_out;
    logic [MBITS:0]             reg_m_store_size_out;
    logic [NBITS:0]             reg_n_store_size_out;
    modport master (
        output load_en_in, mem_load_element_in, mem_m_load_size_in, mem_n_load_size_in, mem_load_addr_in,
        output reg_store_en_in, reg_store_addr_in, reg_i_store_loc_in, reg_j_store_loc_in,
        input  mem_load_error_out, mem_load_ack_out,
        input  reg_store_element_out, reg_m_store_size_out, reg_n_store_size_out
    );
    modport slave (
        input  load_en_in, mem_load_element_in, mem_m_load_size_in, mem_n_load_size_in, mem_load_addr_in,
        input  reg_store_en_in, reg_store_addr_in, reg_i_store_loc_in, reg_j_store_loc_in,
        output mem_load_error_out, mem_load_ack_out,
        output reg_store_element_out, reg_m_store_size_out, reg_n_store_size_out
    );
endinterface

// File: rtl/mpu_load.sv
// mpu_load: load sequencer walking a row-major element stream into one matrix register
module mpu_load
    import global_defs::*, mpu_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_en,
    input  logic [MBITS:0]             m_size,
    input  logic [NBITS:0]             n_size,
    input  logic [MATRIX_REG_SIZE-1:0] addr,
    output logic                       we,
    output logic                       set_size,
    output logic [MATRIX_REG_SIZE-1:0] wr_addr,
    output logic [MBITS-1:0]           wr_i,
    output logic [NBITS-1:0]           wr_j,
    output logic                       error,
    output logic                       ack
);
    load_state_t state, state_d;
    logic [MBITS:0] i_q, i_d, m_q, cur_i, dim_m;
    logic [NBITS:0] j_q, j_d, n_q, cur_j, dim_n;
    logic [MATRIX_REG_SIZE-1:0] addr_q;
    logic start, bad, row_end, last, error_d, ack_d;

    // The start cycle writes element (0,0) using the live sizes; later cycles use the captured ones
    always_comb begin
        start = state == ST_IDLE && load_en;
        bad = m_size == '0 || n_size == '0 || m_size > M_MAX || n_size > N_MAX;
        cur_i = state == ST_LOAD ? i_q : '0;
        cur_j = state == ST_LOAD ? j_q : '0;
        dim_m = state == ST_LOAD ? m_q : m_size;
        dim_n = state == ST_LOAD ? n_q : n_size;
        row_end = cur_j == dim_n - 1'b1;
        last = row_end && cur_i == dim_m - 1'b1;
        we = (start && !bad) || state == ST_LOAD;
        set_size = start && !bad;
        error_d = start && bad;
        ack_d = we && last;
        wr_addr = state == ST_LOAD ? addr_q : addr;
        wr_i = cur_i[MBITS-1:0];
        wr_j = cur_j[NBITS-1:0];
        state_d = we ? (last ? ST_IDLE : ST_LOAD) : state;
        i_d = we && row_end ? cur_i + 1'b1 : cur_i;
        j_d = we ? (row_end ? '0 : cur_j + 1'b1) : cur_j;
    end

    // State, position counters, captured load parameters and registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            i_q <= '0;
            j_q <= '0;
            m_q <= '0;
            n_q <= '0;
            addr_q <= '0;
            error <= 1'b0;
            ack <= 1'b0;
        end else begin
            state <= state_d;
            i_q <= i_d;
            j_q <= j_d;
            if (start) begin
                m_q <= m_size;
                n_q <= n_size;
                addr_q <= addr;
            end
            error <= error_d;
            ack <= ack_d;
        end
    end
endmodule

// File: rtl/mpu_register_file.sv
// mpu_register_file: bank of MxN FP32 matrix registers with stored dimensions and a registered read port
module mpu_register_file
    import global_defs::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic                       set_size,
    input  logic [MATRIX_REG_SIZE-1:0] wr_addr,
    input  logic [MBITS-1:0]           wr_i,
    input  logic [NBITS-1:0]           wr_j,
    input  logic [FP-1:0]              wr_data,
    input  logic [MBITS:0]             wr_m,
    input  logic [NBITS:0]             wr_n,
    input  logic                       rd_en,
    input  logic [MATRIX_REG_SIZE-1:0] rd_addr,
    input  logic [MBITS:0]             rd_i,
    input  logic [NBITS:0]             rd_j,
    output logic [FP-1:0]              rd_data,
    output logic [MBITS:0]             rd_m,
    output logic [NBITS:0]             rd_n
);
    logic [FP-1:0] matrix_register_array [MATRIX_REGISTERS][M][N];
    logic [MBITS:0] m_size [MATRIX_REGISTERS];
    logic [NBITS:0] n_size [MATRIX_REGISTERS];

    // Element and dimension storage; reset wipes every register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < MATRIX_REGISTERS; r++) begin
                m_size[r] <= '0;
                n_size[r] <= '0;
                for (int i = 0; i < M; i++)
                    for (int j = 0; j < N; j++)
                        matrix_register_array[r][i][j] <= '0;
            end
        end else begin
            if (we)
                matrix_register_array[wr_addr][wr_i][wr_j] <= wr_data;
            if (set_size) begin
                m_size[wr_addr] <= wr_m;
                n_size[wr_addr] <= wr_n;
            end
        end
    end

    // Read port sees pre-write contents, so a same-cycle read returns the old value
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_m <= '0;
            rd_n <= '0;
        end else if (rd_en) begin
            rd_data <= rd_i < M_MAX && rd_j < N_MAX ? matrix_register_array[rd_addr][rd_i[MBITS-1:0]][rd_j[NBITS-1:0]] : '0;
            rd_m <= m_size[rd_addr];
            rd_n <= n_size[rd_addr];
        end
    end
endmodule

// File: rtl/mpu_load_regfile.sv
// mpu_load_regfile: MPU matrix load path joining the load sequencer to the matrix register file
module mpu_load_regfile
    import global_defs::*;
(
    input logic               clk,
    input logic               rst,
    mpu_load_regfile_if.slave bus
);
    logic we, set_size;
    logic [MATRIX_REG_SIZE-1:0] wr_addr;
    logic [MBITS-1:0] wr_i;
    logic [NBITS-1:0] wr_j;

    mpu_load u_load (
        .clk(clk), .rst(rst), .load_en(bus.load_en_in),
        .m_size(bus.mem_m_load_size_in), .n_size(bus.mem_n_load_size_in), .addr(bus.mem_load_addr_in),
        .we(we), .set_size(set_size), .wr_addr(wr_addr), .wr_i(wr_i), .wr_j(wr_j),
        .error(bus.mem_load_error_out), .ack(bus.mem_load_ack_out)
    );

    mpu_register_file u_regs (
        .clk(clk), .rst(rst), .we(we), .set_size(set_size), .wr_addr(wr_addr), .wr_i(wr_i), .wr_j(wr_j),
        .wr_data(bus.mem_load_element_in), .wr_m(bus.mem_m_load_size_in), .wr_n(bus.mem_n_load_size_in),
        .rd_en(bus.reg_store_en_in), .rd_addr(bus.reg_store_addr_in),
        .rd_i(bus.reg_i_store_loc_in), .rd_j(bus.reg_j_store_loc_in),
        .rd_data(bus.reg_store_element_out), .rd_m(bus.reg_m_store_size_out), .rd_n(bus.reg_n_store_size_out)
    );
endmodule

// File: tb/tb_mpu_load_regfile.sv
// tb_mpu_load_regfile: table-driven and randomized checks of the matrix load path against a behavioural model
module tb_mpu_load_regfile;
    import global_defs::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mpu_load_regfile_if bus();
    mpu_load_regfile dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [FP-1:0] model [MATRIX_REGISTERS][M][N];
    int msz [MATRIX_REGISTERS];
    int nsz [MATRIX_REGISTERS];

    typedef struct {
        int addr;
        int m;
        int n;
        int err;
        int lat;
    } load_vec_t;
    load_vec_t vecs [9];
    logic [31:0] plan [9];
    logic [31:0] el [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < MATRIX_REGISTERS; r++) begin
            msz[r] = 0;
            nsz[r] = 0;
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++)
                    model[r][i][j] = '0;
        end
    endtask

    // Starts a load at the current negedge and watches a fixed window for ack/error pulses
    task automatic do_load(input int addr, input int m, input int n, input logic [31:0] e [9],
                           input bit reassert, input int exp_err, input int exp_lat, input string tag);
        int total, acks, errs, ack_at, err_at;
        bit bad;
        bad = m == 0 || n == 0 || m > M || n > N;
        total = bad ? 0 : m * n;
        acks = 0; errs = 0; ack_at = 0; err_at = 0;
        bus.load_en_in = 1'b1;
        bus.mem_load_element_in = e[0];
        bus.mem_m_load_size_in = (MBITS+1)'(m);
        bus.mem_n_load_size_in = (NBITS+1)'(n);
        bus.mem_load_addr_in = MATRIX_REG_SIZE'(addr);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.mem_load_ack_out) begin acks++; ack_at = c; end
            if (bus.mem_load_error_out) begin errs++; err_at = c; end
            bus.load_en_in = reassert && c == 3;
            bus.mem_load_addr_in = reassert ? MATRIX_REG_SIZE'(addr ^ 1) : MATRIX_REG_SIZE'($urandom);
            bus.mem_m_load_size_in = (MBITS+1)'($urandom_range(1, M));
            bus.mem_n_load_size_in = (NBITS+1)'($urandom_range(1, N));
            bus.mem_load_element_in = c < total ? e[c] : $urandom;
        end
        bus.load_en_in = 1'b0;
        if (!bad) begin
            for (int k = 0; k < total; k++) model[addr][k / n][k % n] = e[k];
            msz[addr] = m;
            nsz[addr] = n;
        end
        chk($sformatf("%s ack count", tag), acks, exp_err != 0 ? 0 : 1);
        chk($sformatf("%s ack latency", tag), ack_at, exp_lat);
        chk($sformatf("%s error count", tag), errs, exp_err);
        if (exp_err != 0) chk($sformatf("%s error latency", tag), err_at, 1);
    endtask

    task automatic read_chk(input int a, input int i, input int j);
        logic [31:0] exp;
        bus.reg_store_en_in = 1'b1;
        bus.reg_store_addr_in = MATRIX_REG_SIZE'(a);
        bus.reg_i_store_loc_in = (MBITS+1)'(i);
        bus.reg_j_store_loc_in = (NBITS+1)'(j);
        @(negedge clk);
        bus.reg_store_en_in = 1'b0;
        exp = '0;
        if (i < M && j < N) exp = model[a][i][j];
        chk($sformatf("rd[%0d][%0d][%0d] elem", a, i, j), bus.reg_store_element_out, exp);
        chk($sformatf("rd[%0d] m", a), 32'(bus.reg_m_store_size_out), msz[a]);
        chk($sformatf("rd[%0d] n", a), 32'(bus.reg_n_store_size_out), nsz[a]);
    endtask

    task automatic check_reg(input int a);
        for (int i = 0; i <= M; i++)
            for (int j = 0; j <= N; j++)
                read_chk(a, i, j);
    endtask

    initial begin
        plan = '{32'h3f800000, 32'h424951ec, 32'hc0200000, 32'h3e000000, 32'hbeaaaa9f,
                 32'h4e932c06, 32'h00000000, 32'hb6a7c5ac, 32'hd0132c06};
        vecs[0] = '{0, 3, 3, 0, 9};
        vecs[1] = '{1, 3, 3, 0, 9};
        vecs[2] = '{1, 2, 2, 0, 4};
        vecs[3] = '{1, 0, 2, 1, 0};
        vecs[4] = '{1, 3, 4, 1, 0};
        vecs[5] = '{2, 1, 1, 0, 1};
        vecs[6] = '{2, 1, 3, 0, 3};
        vecs[7] = '{3, 3, 1, 0, 3};
        vecs[8] = '{3, 4, 1, 1, 0};
        clear_model();
        rst = 1'b1;
        bus.load_en_in = 1'b0;
        bus.mem_load_element_in = '0;
        bus.mem_m_load_size_in = '0;
        bus.mem_n_load_size_in = '0;
        bus.mem_load_addr_in = '0;
        bus.reg_store_en_in = 1'b0;
        bus.reg_store_addr_in = '0;
        bus.reg_i_store_loc_in = '0;
        bus.reg_j_store_loc_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset error", 32'(bus.mem_load_error_out), 0);
        chk("reset ack", 32'(bus.mem_load_ack_out), 0);
        chk("reset elem", bus.reg_store_element_out, 0);
        chk("reset m", 32'(bus.reg_m_store_size_out), 0);
        chk("reset n", 32'(bus.reg_n_store_size_out), 0);
        check_reg(0);

        for (int t = 0; t < 9; t++) begin
            for (int k = 0; k < 9; k++) el[k] = t == 0 ? plan[k] : $urandom;
            do_load(vecs[t].addr, vecs[t].m, vecs[t].n, el, 1'b0, vecs[t].err, vecs[t].lat, $sformatf("vec%0d", t));
            check_reg(vecs[t].addr);
        end

        read_chk(1, 1, 1);
        bus.reg_store_addr_in = 2'd0;
        bus.reg_i_store_loc_in = 3'd2;
        bus.reg_j_store_loc_in = 3'd2;
        @(negedge clk);
        chk("hold elem", bus.reg_store_element_out, model[1][1][1]);

        for (int k = 0; k < 9; k++) el[k] = $urandom;
        do_load(2, 3, 3, el, 1'b1, 0, 9, "reassert");
        check_reg(2);
        check_reg(3);

        el[0] = ~model[0][0][0];
        bus.load_en_in = 1'b1;
        bus.mem_load_element_in = el[0];
        bus.mem_m_load_size_in = 3'd1;
        bus.mem_n_load_size_in = 3'd1;
        bus.mem_load_addr_in = 2'd0;
        bus.reg_store_en_in = 1'b1;
        bus.reg_store_addr_in = 2'd0;
        bus.reg_i_store_loc_in = 3'd0;
        bus.reg_j_store_loc_in = 3'd0;
        @(negedge clk);
        bus.load_en_in = 1'b0;
        bus.reg_store_en_in = 1'b0;
        chk("rw same cycle old value", bus.reg_store_element_out, model[0][0][0]);
        chk("rw same cycle ack", 32'(bus.mem_load_ack_out), 1);
        model[0][0][0] = el[0];
        msz[0] = 1;
        nsz[0] = 1;
        read_chk(0, 0, 0);

        for (int r = 0; r < 25; r++) begin
            int a, m, n, bad;
            a = $urandom_range(0, MATRIX_REGISTERS - 1);
            m = $urandom_range(0, M + 1);
            n = $urandom_range(0, N + 1);
            bad = (m == 0 || n == 0 || m > M || n > N) ? 1 : 0;
            for (int k = 0; k < 9; k++) el[k] = $urandom;
            do_load(a, m, n, el, 1'b0, bad, bad != 0 ? 0 : m * n, $sformatf("rnd%0d", r));
            for (int q = 0; q < 4; q++)
                read_chk($urandom_range(0, MATRIX_REGISTERS - 1), $urandom_range(0, M), $urandom_range(0, N));
        end

        read_chk(0, 0, 0);
        for (int k = 0; k < 9; k++) el[k] = $urandom | 32'h1;
        bus.load_en_in = 1'b1;
        bus.mem_load_element_in = el[0];
        bus.mem_m_load_size_in = 3'd3;
        bus.mem_n_load_size_in = 3'd3;
        bus.mem_load_addr_in = 2'd0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.load_en_in = 1'b0;
            bus.mem_load_element_in = el[c];
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort error", 32'(bus.mem_load_error_out), 0);
        chk("abort ack", 32'(bus.mem_load_ack_out), 0);
        chk("abort elem", bus.reg_store_element_out, 0);
        chk("abort m", 32'(bus.reg_m_store_size_out), 0);
        chk("abort n", 32'(bus.reg_n_store_size_out), 0);
        begin
            int acks;
            acks = 0;
            for (int c = 0; c < 10; c++) begin
                bus.mem_load_element_in = $urandom;
                @(negedge clk);
                if (bus.mem_load_ack_out) acks++;
            end
            chk("abort later acks", acks, 0);
        end
        clear_model();
        check_reg(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
